mem_loader: RTL and testbench

//  Front end of the 16x8 program RAM: a byte-stream loader that writes a program into RAM
//  at power-up or on operator request. In PROG mode it owns the RAM write port and halts the
//  CPU. In RUN mode it passes the CPU's address, data and load lines straight through to the RAM.

---
 rtl/mem_loader_pkg.sv | 15 +
 rtl/mem_loader_if.sv | 25 ++
 rtl/mem_loader.sv | 104 ++++++++++
 tb/tb_mem_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared constants and loader state encoding for the program-RAM front end.
package mem_loader_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 16;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_RECV,
      LD_WRITE,
      LD_DONE
   } ld_state_e;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream, CPU-side and RAM-side signals of the program loader.
interface mem_loader_if;
   import mem_loader_pkg::*;

   logic              byte_valid;
   logic [DATA_W-1:0] byte_data;
   logic              byte_ready;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_data;
   logic              cpu_load;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_load;

   modport slave (
      input  byte_valid, byte_data, cpu_addr, cpu_data, cpu_load,
      output byte_ready, mem_addr, mem_data, mem_load
   );

   modport master (
      output byte_valid, byte_data, cpu_addr, cpu_data, cpu_load,
      input  byte_ready, mem_addr, mem_data, mem_load
   );

endinterface

// File: rtl/mem_loader.sv
// Byte-stream loader for the 16x8 program RAM; passes the CPU bus through in run mode.
// Optional feature: define CHECKSUM_EN for a mod-256 sum of accepted bytes.
module mem_loader
   import mem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_mode,
   mem_loader_if.slave       bus,
   output logic              cpu_halt,
   output logic              load_done,
   output logic [DATA_W-1:0] checksum
);

   ld_state_e         state;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] byte_q;
   logic              ready_q;
   logic              load_q;
`ifdef CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
`endif

   // Loader FSM; all outputs are registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LD_IDLE;
         wr_addr   <= '0;
         byte_q    <= '0;
         ready_q   <= 1'b0;
         load_q    <= 1'b0;
         cpu_halt  <= 1'b0;
         load_done <= 1'b0;
`ifdef CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         case (state)
            LD_IDLE: begin
               if (prog_mode) begin
                  state    <= LD_RECV;
                  wr_addr  <= '0;
                  ready_q  <= 1'b1;
                  cpu_halt <= 1'b1;
`ifdef CHECKSUM_EN
                  csum_q   <= '0;
`endif
               end
            end
            LD_RECV: begin
               // A byte offered while ready is high has transferred, even if prog_mode just fell
               if (bus.byte_valid) begin
                  state   <= LD_WRITE;
                  byte_q  <= bus.byte_data;
                  ready_q <= 1'b0;
                  load_q  <= 1'b1;
`ifdef CHECKSUM_EN
                  csum_q  <= DATA_W'(csum_q + bus.byte_data);
`endif
               end else if (!prog_mode) begin
                  state    <= LD_IDLE;
                  ready_q  <= 1'b0;
                  cpu_halt <= 1'b0;
               end
            end
            LD_WRITE: begin
               load_q <= 1'b0;
               if (!prog_mode) begin
                  state    <= LD_IDLE;
                  cpu_halt <= 1'b0;
               end else if (wr_addr == ADDR_W'(DEPTH - 1)) begin
                  state     <= LD_DONE;
                  load_done <= 1'b1;
               end else begin
                  state   <= LD_RECV;
                  wr_addr <= ADDR_W'(wr_addr + 1'b1);
                  ready_q <= 1'b1;
               end
            end
            LD_DONE: begin
               if (!prog_mode) begin
                  state     <= LD_IDLE;
                  cpu_halt  <= 1'b0;
                  load_done <= 1'b0;
               end
            end
            default: state <= LD_IDLE;
         endcase
      end
   end

   // Run-mode pass-through is the only combinational path to the RAM
   assign bus.mem_addr   = (state == LD_IDLE) ? bus.cpu_addr : wr_addr;
   assign bus.mem_data   = (state == LD_IDLE) ? bus.cpu_data : byte_q;
   assign bus.mem_load   = (state == LD_IDLE) ? bus.cpu_load : load_q;
   assign bus.byte_ready = ready_q;

`ifdef CHECKSUM_EN
   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: transaction-level model plus directed and random stimulus.
module tb_mem_loader;
   import mem_loader_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       prog_mode = 1'b0;
   logic       cpu_halt;
   logic       load_done;
   logic [7:0] checksum;

   mem_loader_if bus();

   mem_loader dut (
      .clk       (clk),
      .rst       (rst),
      .prog_mode (prog_mode),
      .bus       (bus),
      .cpu_halt  (cpu_halt),
      .load_done (load_done),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Model: the loader either owns the RAM (active) or not; bytes accepted so far,
   // and at most one accepted byte waiting to hit the RAM on the following cycle.
   bit         started = 0;
   bit         m_active = 0;
   bit         m_pending = 0;
   int         m_count = 0;
   logic [3:0] m_paddr = '0;
   logic [7:0] m_pdata = '0;
   logic [7:0] m_csum = '0;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;
   wr_t wlog[$];

   always @(posedge clk) begin
      if (rst) begin
         started   = 1;
         m_active  = 0;
         m_pending = 0;
         m_count   = 0;
         m_csum    = '0;
      end else if (!m_active) begin
         if (prog_mode) begin
            m_active = 1;
            m_count  = 0;
            m_csum   = '0;
         end
      end else if (m_pending) begin
         m_pending = 0;
         if (!prog_mode) m_active = 0;
      end else if (m_count < DEPTH && bus.byte_valid) begin
         m_pending = 1;
         m_paddr   = 4'(m_count);
         m_pdata   = bus.byte_data;
         m_count++;
         m_csum    = 8'(m_csum + bus.byte_data);
      end else if (!prog_mode) begin
         m_active = 0;
      end
   end

   // Per-cycle comparison against the model, plus a log of loader-issued writes
   always @(negedge clk) begin
      if (started) begin
         logic [7:0] exp_csum;
`ifdef CHECKSUM_EN
         exp_csum = m_csum;
`else
         exp_csum = 8'h00;
`endif
         if (!m_active) begin
            check("pass_load", int'(bus.mem_load), int'(bus.cpu_load));
            check("pass_addr", int'(bus.mem_addr), int'(bus.cpu_addr));
            check("pass_data", int'(bus.mem_data), int'(bus.cpu_data));
         end else begin
            check("mem_load", int'(bus.mem_load), int'(m_pending));
            if (m_pending) begin
               check("wr_addr", int'(bus.mem_addr), int'(m_paddr));
               check("wr_data", int'(bus.mem_data), int'(m_pdata));
            end
         end
         check("byte_ready", int'(bus.byte_ready),
               int'(m_active && !m_pending && m_count < DEPTH));
         check("cpu_halt", int'(cpu_halt), int'(m_active));
         check("load_done", int'(load_done),
               int'(m_active && !m_pending && m_count == DEPTH));
         check("checksum", int'(checksum), int'(exp_csum));
         if (cpu_halt && bus.mem_load) wlog.push_back('{a: bus.mem_addr, d: bus.mem_data});
      end
   end

   // Offer one byte and hold it until it transfers; optionally drop valid for gap cycles
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got;
      got = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (bus.byte_ready) got = 1;
      end
      if (!got) begin
         check("send_timeout", 0, 1);
         bus.byte_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_sum;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      bus.cpu_addr   = 4'h5;
      bus.cpu_data   = 8'hA3;
      bus.cpu_load   = 1'b1;

      // Reset and run-mode pass-through
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      settle();
      check("t1_halt", int'(cpu_halt), 0);
      check("t1_ready", int'(bus.byte_ready), 0);
      check("t1_done", int'(load_done), 0);
      check("t1_csum", int'(checksum), 0);
      check("t1_addr", int'(bus.mem_addr), 32'h5);
      check("t1_data", int'(bus.mem_data), 32'hA3);
      check("t1_load", int'(bus.mem_load), 1);

      // Back-to-back image 0x10..0x1F
      bus.cpu_load = 1'b0;
      wlog.delete();
      @(posedge clk);
      #1;
      prog_mode = 1'b1;
      for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 0);
      @(posedge clk);
      settle();
      check("t2_nwrites", wlog.size(), 16);
      for (int i = 0; i < 16; i++)
         if (i < wlog.size()) begin
            check("t2_addr", int'(wlog[i].a), i);
            check("t2_data", int'(wlog[i].d), 16 + i);
         end
      check("t2_done", int'(load_done), 1);
`ifdef CHECKSUM_EN
      exp_sum = 8'h78;
`else
      exp_sum = 8'h00;
`endif
      check("t2_csum", int'(checksum), int'(exp_sum));

      // Extra bytes in DONE are stalled
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hEE;
      repeat (10) begin
         @(negedge clk);
         check("t6_ready", int'(bus.byte_ready), 0);
      end
      #1;
      check("t6_nwrites", wlog.size(), 16);
      bus.byte_valid = 1'b0;
      bus.cpu_addr   = 4'h9;
      bus.cpu_data   = 8'h3C;
      bus.cpu_load   = 1'b1;
      @(posedge clk);
      #1;
      prog_mode = 1'b0;
      @(posedge clk);
      settle();
      check("t6_halt", int'(cpu_halt), 0);
      check("t6_done", int'(load_done), 0);
      check("t6_load", int'(bus.mem_load), 1);
      check("t6_addr", int'(bus.mem_addr), 32'h9);
      check("t6_csum_held", int'(checksum), int'(exp_sum));

      // Gapped stream of 0xFF
      bus.cpu_load = 1'b0;
      wlog.delete();
      @(posedge clk);
      #1;
      prog_mode = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) send_byte(8'hFF, 3);
      settle();
      check("t3_nwrites", wlog.size(), 16);
      for (int i = 0; i < 16; i++)
         if (i < wlog.size()) check("t3_addr", int'(wlog[i].a), i);
`ifdef CHECKSUM_EN
      check("t3_csum", int'(checksum), 32'hF0);
`else
      check("t3_csum", int'(checksum), 0);
`endif
      check("t3_done", int'(load_done), 1);
      @(posedge clk);
      #1;
      prog_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // prog_mode falls after five bytes, during the fifth write
      wlog.delete();
      prog_mode = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 0);
      bus.byte_valid = 1'b0;
      prog_mode      = 1'b0;
      bus.cpu_load   = 1'b1;
      @(posedge clk);
      settle();
      check("t4_nwrites", wlog.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < wlog.size()) check("t4_addr", int'(wlog[i].a), i);
      check("t4_halt", int'(cpu_halt), 0);
      check("t4_done", int'(load_done), 0);
      check("t4_load", int'(bus.mem_load), 1);

      // Reset lands during a write
      bus.cpu_load = 1'b0;
      @(posedge clk);
      #1;
      prog_mode = 1'b1;
      @(posedge clk);
      #1;
      send_byte(8'h77, 0);
      bus.byte_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      settle();
      check("t5_halt", int'(cpu_halt), 0);
      check("t5_ready", int'(bus.byte_ready), 0);
      check("t5_load", int'(bus.mem_load), 0);
      check("t5_csum", int'(checksum), 0);
      rst = 1'b0;
      prog_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         rst            = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 59) == 0) prog_mode = ~prog_mode;
         bus.byte_valid = 1'($urandom_range(0, 1));
         bus.byte_data  = 8'($urandom);
         bus.cpu_addr   = 4'($urandom);
         bus.cpu_data   = 8'($urandom);
         bus.cpu_load   = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      settle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
